// File: rtl/board_move_collector_if.sv
// Board move collector bus: column FIFO side, move stream side and status.
interface board_move_collector_if #(
    parameter int NCOL  = 8,
    parameter int WIDTH = 160,
    parameter int CNTW  = 16
);
    logic [NCOL*WIDTH-1:0] col_data;
    logic [NCOL-1:0]       col_empty;
    logic [NCOL-1:0]       col_done;
    logic [NCOL-1:0]       col_rden;
    logic [WIDTH-1:0]      move_data;
    logic                  move_valid;
    logic                  move_ready;
    logic [CNTW-1:0]       move_count;
    logic [NCOL-1:0]       drained;
    logic                  all_done;

    // Collector side
    modport master (
        input  col_data, col_empty, col_done, move_ready,
        output col_rden, move_data, move_valid, move_count, drained, all_done
    );

    // Column units plus move consumer side
    modport slave (
        output col_data, col_empty, col_done, move_ready,
        input  col_rden, move_data, move_valid, move_count, drained, all_done
    );
endinterface

// File: rtl/board_move_collector.sv
// Round-robin drain of the column move FIFOs into one valid/ready move stream,
// with per-column drained tracking and a board-level done flag.
//
// state | meaning
// SCAN  | inspect column ptr: read it, stall on full buffer, mark drained, or advance
// READ  | column word from last cycle's read is on col_data; push it
// DONE  | every column drained; all_done rises once the buffer has emptied
module board_move_collector #(
    parameter int NCOL  = 8,
    parameter int WIDTH = 160,
    parameter int CNTW  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    board_move_collector_if.master bus
);
    localparam int PTRW = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam logic [PTRW-1:0] PTR_LAST = PTRW'(NCOL - 1);

    typedef enum logic [1:0] {SCAN, READ, DONE} state_t;

    state_t            state;
    logic [PTRW-1:0]   ptr;
    logic [1:0]        occ;
    logic [WIDTH-1:0]  buf0;
    logic [WIDTH-1:0]  buf1;
    logic              move_valid_q;
    logic [CNTW-1:0]   move_count_q;
    logic [NCOL-1:0]   drained_q;
    logic              all_done_q;

    logic [WIDTH-1:0]  col_word [NCOL];
    logic [WIDTH-1:0]  sel_data;
    logic              sel_empty;
    logic              sel_done;
    logic              sel_drained;
    logic [NCOL-1:0]   sel_bit;
    logic              pop;
    logic              push;
    logic [1:0]        occ_after_pop;
    logic [1:0]        occ_next;
    logic              do_read;
    logic              do_mark;
    logic [NCOL-1:0]   drained_next;
    logic [PTRW-1:0]   ptr_next;
    logic [NCOL-1:0]   rden;

    for (genvar g = 0; g < NCOL; g++) begin : g_col_word
        assign col_word[g] = bus.col_data[g*WIDTH +: WIDTH];
    end

    // Selected-column view, buffer occupancy bookkeeping and the read decision.
    // The read request is a same-cycle pulse so the word lands in READ.
    always_comb begin
        sel_data      = col_word[ptr];
        sel_empty     = bus.col_empty[ptr];
        sel_done      = bus.col_done[ptr];
        sel_drained   = drained_q[ptr];
        sel_bit       = NCOL'(1) << ptr;
        pop           = move_valid_q & bus.move_ready;
        push          = (state == READ);
        occ_after_pop = occ - {1'b0, pop};
        occ_next      = occ + {1'b0, push} - {1'b0, pop};
        do_read       = (state == SCAN) && !sel_drained && !sel_empty && (occ_after_pop <= 2'd1);
        do_mark       = (state == SCAN) && !sel_drained && sel_empty && sel_done;
        drained_next  = drained_q | (do_mark ? sel_bit : '0);
        ptr_next      = (ptr == PTR_LAST) ? '0 : ptr + PTRW'(1);
        rden          = '0;
        if (do_read) begin
            rden = sel_bit;
        end
    end

    // Sequencing FSM: column pointer, sticky drained flags and board done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SCAN;
            ptr        <= '0;
            drained_q  <= '0;
            all_done_q <= 1'b0;
        end else begin
            unique case (state)
                SCAN: begin
                    drained_q <= drained_next;
                    if (do_read) begin
                        state <= READ;
                    end else if (!sel_drained && !sel_empty) begin
                        // buffer full: hold on this column until a pop frees space
                        state <= SCAN;
                    end else begin
                        ptr <= ptr_next;
                    end
                    if (&drained_next) begin
                        state <= DONE;
                    end
                end
                READ: begin
                    // ptr unchanged so the same column bursts until empty
                    state <= SCAN;
                end
                DONE: begin
                    all_done_q <= (occ_next == 2'd0);
                end
                default: begin
                    state <= SCAN;
                end
            endcase
        end
    end

    // Two-entry output buffer (buf0 is the head) and saturating accepted-move count.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ          <= '0;
            buf0         <= '0;
            buf1         <= '0;
            move_valid_q <= 1'b0;
            move_count_q <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) buf0 <= sel_data;
                    else             buf1 <= sel_data;
                end
                2'b01: begin
                    buf0 <= buf1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf0 <= sel_data;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= sel_data;
                    end
                end
                default: ;
            endcase
            occ          <= occ_next;
            move_valid_q <= (occ_next != 2'd0);
            if (pop && (move_count_q != '1)) begin
                move_count_q <= move_count_q + CNTW'(1);
            end
        end
    end

    assign bus.col_rden   = rden;
    assign bus.move_data  = buf0;
    assign bus.move_valid = move_valid_q;
    assign bus.move_count = move_count_q;
    assign bus.drained    = drained_q;
    assign bus.all_done   = all_done_q;
endmodule

// File: tb/tb_board_move_collector.sv
// Directed bench for board_move_collector: column FIFO models with one-cycle
// read latency, a move capture log and hand-computed expectations.
module tb_board_move_collector;
    localparam int NCOL  = 8;
    localparam int WIDTH = 160;
    // narrow counter so saturation is reachable within a short run
    localparam int CNTW  = 4;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    board_move_collector_if #(.NCOL(NCOL), .WIDTH(WIDTH), .CNTW(CNTW)) bus ();

    board_move_collector #(.NCOL(NCOL), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] mem [NCOL][DEPTH];
    int               wr [NCOL];
    int               rd [NCOL];
    logic [WIDTH-1:0] cap [64];
    int               cap_n;
    int               rden_cnt;
    int               rt [64];
    logic [NCOL-1:0]  last_rden;
    int               rden_viol;
    int               cyc;
    int               n_checks;
    int               n_errors;

    function automatic logic [WIDTH-1:0] mk(input int c, input int k);
        logic [31:0] w;
        w = 32'hA500_0000 ^ 32'(c * 4096 + k * 17 + 1);
        return {w, ~w, w ^ 32'h0F0F_0F0F, 32'(k), 32'(c)};
    endfunction

    task automatic check_val(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic put(input int c, input int k);
        mem[c][wr[c] % DEPTH] = mk(c, k);
        wr[c] = wr[c] + 1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        flush = 1'b0;
    endtask

    task automatic wait_all_done(input string tag, input int bound);
        int k;
        k = 0;
        while (!bus.all_done && k < bound) begin
            @(negedge clk);
            k++;
        end
        check_val(tag, WIDTH'(bus.all_done), WIDTH'(1));
    endtask

    // Empty flags follow the model FIFO pointers
    always_comb begin
        bus.col_empty = '0;
        for (int i = 0; i < NCOL; i++) begin
            bus.col_empty[i] = (rd[i] == wr[i]);
        end
    end

    // Column FIFO read port plus stream capture and read-request monitoring
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (flush) begin
            for (int i = 0; i < NCOL; i++) rd[i] <= wr[i];
            cap_n    <= 0;
            rden_cnt <= 0;
        end else begin
            if ($countones(bus.col_rden) > 1) rden_viol <= rden_viol + 1;
            for (int i = 0; i < NCOL; i++) begin
                if (bus.col_rden[i]) begin
                    if (rd[i] == wr[i]) rden_viol <= rden_viol + 1;
                    else begin
                        bus.col_data[i*WIDTH +: WIDTH] <= mem[i][rd[i] % DEPTH];
                        rd[i] <= rd[i] + 1;
                    end
                end
            end
            if (bus.col_rden != '0) begin
                if (rden_cnt < 64) rt[rden_cnt] <= cyc;
                rden_cnt  <= rden_cnt + 1;
                last_rden <= bus.col_rden;
            end
            if (bus.move_valid && bus.move_ready && cap_n < 64) begin
                cap[cap_n] <= bus.move_data;
                cap_n      <= cap_n + 1;
            end
        end
    end

    initial begin
        int k;
        logic cond;
        n_checks  = 0;
        n_errors  = 0;
        cyc       = 0;
        rden_viol = 0;
        cap_n     = 0;
        rden_cnt  = 0;
        last_rden = '0;
        for (int i = 0; i < NCOL; i++) begin
            wr[i] = 0;
            rd[i] = 0;
        end
        bus.col_data   = '0;
        bus.col_done   = '1;
        bus.move_ready = 1'b0;

        // Reset values, then an all-idle board drains without any read
        reset = 1'b1;
        flush = 1'b1;
        repeat (2) @(negedge clk);
        check_val("rst_rden",  WIDTH'(bus.col_rden),   WIDTH'(0));
        check_val("rst_valid", WIDTH'(bus.move_valid), WIDTH'(0));
        check_val("rst_data",  bus.move_data,          WIDTH'(0));
        check_val("rst_count", WIDTH'(bus.move_count), WIDTH'(0));
        check_val("rst_drain", WIDTH'(bus.drained),    WIDTH'(0));
        check_val("rst_done",  WIDTH'(bus.all_done),   WIDTH'(0));
        reset = 1'b0;
        flush = 1'b0;
        repeat (7) @(negedge clk);
        check_val("idle_drain7", WIDTH'(bus.drained), WIDTH'(8'h7F));
        @(negedge clk);
        check_val("idle_drain8", WIDTH'(bus.drained),  WIDTH'(8'hFF));
        check_val("idle_done8",  WIDTH'(bus.all_done), WIDTH'(0));
        @(negedge clk);
        check_val("idle_done9",  WIDTH'(bus.all_done),   WIDTH'(1));
        check_val("idle_rdens",  WIDTH'(rden_cnt),       WIDTH'(0));
        check_val("idle_count",  WIDTH'(bus.move_count), WIDTH'(0));

        // Column 3 bursts three words, two cycles per read
        bus.col_done   = '1;
        bus.move_ready = 1'b1;
        do_reset();
        put(3, 0); put(3, 1); put(3, 2);
        wait_all_done("c3_done", 100);
        check_val("c3_rdens", WIDTH'(rden_cnt),  WIDTH'(3));
        check_val("c3_rval",  WIDTH'(last_rden), WIDTH'(8'h08));
        check_val("c3_gap1",  WIDTH'(rt[1] - rt[0]), WIDTH'(2));
        check_val("c3_gap2",  WIDTH'(rt[2] - rt[1]), WIDTH'(2));
        check_val("c3_ncap",  WIDTH'(cap_n), WIDTH'(3));
        check_val("c3_w0",    cap[0], mk(3, 0));
        check_val("c3_w1",    cap[1], mk(3, 1));
        check_val("c3_w2",    cap[2], mk(3, 2));
        check_val("c3_count", WIDTH'(bus.move_count), WIDTH'(3));

        // Backpressure: columns 0 and 5 with consumer stalled
        bus.move_ready = 1'b0;
        do_reset();
        put(0, 0); put(0, 1); put(5, 0); put(5, 1);
        repeat (30) @(negedge clk);
        check_val("bp_rdens", WIDTH'(rden_cnt),       WIDTH'(2));
        check_val("bp_valid", WIDTH'(bus.move_valid), WIDTH'(1));
        check_val("bp_head",  bus.move_data,          mk(0, 0));
        check_val("bp_done",  WIDTH'(bus.all_done),   WIDTH'(0));
        bus.move_ready = 1'b1;
        wait_all_done("bp_alldone", 100);
        check_val("bp_ncap",  WIDTH'(cap_n), WIDTH'(4));
        check_val("bp_w0",    cap[0], mk(0, 0));
        check_val("bp_w1",    cap[1], mk(0, 1));
        check_val("bp_w2",    cap[2], mk(5, 0));
        check_val("bp_w3",    cap[3], mk(5, 1));
        check_val("bp_count", WIDTH'(bus.move_count), WIDTH'(4));

        // Idle, not-done column 2 is passed over; column 6 still read
        bus.col_done   = 8'hFB;
        bus.move_ready = 1'b1;
        do_reset();
        put(6, 0);
        repeat (40) @(negedge clk);
        check_val("idle2_ncap",  WIDTH'(cap_n),        WIDTH'(1));
        check_val("idle2_w0",    cap[0],               mk(6, 0));
        check_val("idle2_drain", WIDTH'(bus.drained),  WIDTH'(8'hFB));
        check_val("idle2_done",  WIDTH'(bus.all_done), WIDTH'(0));
        bus.col_done = 8'hFF;
        wait_all_done("idle2_alldone", 50);
        check_val("idle2_drainf", WIDTH'(bus.drained), WIDTH'(8'hFF));

        // Reset while a READ is in flight with one word buffered
        bus.col_done   = '1;
        bus.move_ready = 1'b1;
        do_reset();
        put(1, 0); put(1, 1); put(1, 2);
        k = 0;
        while (bus.move_count == '0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        bus.move_ready = 1'b0;
        check_val("mid_count1", WIDTH'(bus.move_count), WIDTH'(1));
        k = 0;
        do begin
            @(negedge clk);
            k++;
            cond = (bus.col_rden != '0) && bus.move_valid;
        end while (!cond && k < 20);
        check_val("mid_rden_seen", WIDTH'(cond), WIDTH'(1));
        @(negedge clk);
        check_val("mid_occ1", WIDTH'(bus.move_valid), WIDTH'(1));
        reset = 1'b1;
        @(negedge clk);
        check_val("mid_valid", WIDTH'(bus.move_valid), WIDTH'(0));
        check_val("mid_rden",  WIDTH'(bus.col_rden),   WIDTH'(0));
        check_val("mid_count", WIDTH'(bus.move_count), WIDTH'(0));
        check_val("mid_drain", WIDTH'(bus.drained),    WIDTH'(0));

        // Counter saturation at all ones with further accepted moves
        bus.col_done   = '1;
        bus.move_ready = 1'b1;
        do_reset();
        for (int j = 0; j < 9; j++) put(4, j);
        for (int j = 0; j < 8; j++) put(7, j);
        wait_all_done("sat_alldone", 200);
        check_val("sat_ncap",  WIDTH'(cap_n), WIDTH'(17));
        check_val("sat_count", WIDTH'(bus.move_count), WIDTH'(4'hF));
        check_val("sat_w0",    cap[0],  mk(4, 0));
        check_val("sat_w8",    cap[8],  mk(4, 8));
        check_val("sat_w9",    cap[9],  mk(7, 0));
        check_val("sat_w16",   cap[16], mk(7, 7));

        check_val("rden_onehot", WIDTH'(rden_viol), WIDTH'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/board_move_collector.md
Name: board_move_collector

Overview:
- Sits directly downstream of the eight column units. Drains each column's move FIFO into a single board-wide move stream with valid/ready handshake.
- Detects when every column has finished generation and been fully emptied, then raises a board-level done flag.
- Feeds the move selection / evaluation stage.

Parameters:
- NCOL, 8, number of column units (one per file a..h; index = xpos)
- WIDTH, 160, width of one column FIFO word (passed through unmodified)
- CNTW, 16, width of move counter

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- col_data  in  NCOL*WIDTH  column FIFO q outputs; column i at [i*WIDTH +: WIDTH]
- col_empty  in  NCOL  column FIFO empty flags
- col_done  in  NCOL  column done flags (column state machine in DONE)
- col_rden  out  NCOL  column FIFO read requests, one-hot or zero
- move_data  out  WIDTH  head move word
- move_valid  out  1  move_data valid
- move_ready  in  1  consumer accepts when move_valid && move_ready
- move_count  out  CNTW  moves accepted by consumer since reset
- drained  out  NCOL  per-column "done and emptied" flags
- all_done  out  1  every column drained and output buffer empty

Behaviour:
- Reset: col_rden=0, move_valid=0, move_data=0, move_count=0, drained=0, all_done=0, ptr=0, state=SCAN, output buffer flushed. Reset mid-operation discards any in-flight read.
- Column FIFO read latency is 1 cycle: data for rden in cycle t appears on col_data in cycle t+1. The empty flag is trusted only with no read in flight.
- Output buffer: 2-entry FIFO (occ 0..2), head drives move_data/move_valid. move_valid=(occ!=0). Pop on move_valid&&move_ready.
- State SCAN, column ptr:
  - If !col_empty[ptr] and occ-after-pop <= 1: assert col_rden[ptr] for exactly this cycle, go READ.
  - Else if !col_empty[ptr] and buffer full: stay, no rden.
  - Else if col_empty[ptr] and col_done[ptr]: set drained[ptr], advance ptr.
  - Else (empty, not done): advance ptr. Never block on an idle column.
  - If drained is all ones: go DONE.
- State READ: col_rden=0. Push col_data[ptr] into the output buffer. Space is guaranteed by the SCAN check. Go SCAN with ptr unchanged, so a column bursts until empty.
  - Simultaneous push and pop in the same cycle is legal; occ is unchanged.
- ptr advance: ptr = (ptr+1) mod NCOL. Already-drained columns are skipped in one cycle each.
- State DONE: no rden issued. all_done=1 once occ==0; it is registered and rises the cycle after the last pop. DONE is held until reset.
- Throughput: at most one move every 2 cycles.
- move_count increments on each accepted pop and saturates at 2^CNTW-1 (no wrap).
- drained bits are sticky. A column's done flag falling after drained is set is ignored.
- At most one col_rden bit is high in any cycle, and only when the selected column's empty flag is low.
- Data words are forwarded bit-exact, in FIFO order per column. Column order follows the round-robin ptr starting at 0.

Test Plan:
- Reset, then all col_done=1, all col_empty=1 -> no rden ever; drained=8'hFF after 8 SCAN cycles; all_done=1 one cycle later; move_count=0.
- Column 3 holds 3 words (A,B,C), others done and empty, move_ready=1 -> col_rden=8'h08 pulses 3 times, 2 cycles apart; move_data A,B,C in order; move_count=3; all_done=1.
- Columns 0 and 5 each hold 2 words, move_ready=0 -> exactly 2 reads, then col_rden stays 0 with occ=2. Raise move_ready -> remaining words delivered; total 4; col0 words precede col5 words.
- Column 2 empty and not done while column 6 has data -> ptr passes column 2 and reads column 6. Later set col_done[2] -> drained[2]=1, all_done follows.
- Assert reset during READ with occ=1 -> next cycle move_valid=0, col_rden=0, move_count=0, drained=0.
- Force move_count to 16'hFFFF with a further accepted move -> move_count holds 16'hFFFF.
